// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered bitwise gate unit with valid/ready handshake.
// Each accepted beat computes one of eight bitwise ops plus reduction flags.
// The result and its flags are stored together in a 2-entry output FIFO, and
// the outputs always reflect the head entry. A saturating counter tracks
// accepted XNOR beats whose operands are equal.
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_all,
  output logic             out_any,
  output logic             out_par,
  output logic [CNT_W-1:0] match_cnt,
  input  logic             clr_cnt
);

  // Entry layout: {par, any, all, data}
  localparam int EW = WIDTH + 3;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [EW-1:0]    entry_q [2];
  logic [EW-1:0]    entry_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic [WIDTH-1:0] result;
  logic [EW-1:0]    new_entry;
  logic [EW-1:0]    head;
  logic             push;
  logic             pop;

  // Handshake is decided from the registered occupancy only, so in_ready
  // never combinationally depends on out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Operation select and per-beat reduction flags for the incoming operands
  always_comb begin
    result = '0;
    case (in_op)
      OP_AND:  result = in_a & in_b;
      OP_OR:   result = in_a | in_b;
      OP_XOR:  result = in_a ^ in_b;
      OP_XNOR: result = ~(in_a ^ in_b);
      OP_NAND: result = ~(in_a & in_b);
      OP_NOR:  result = ~(in_a | in_b);
      OP_NOTA: result = ~in_a;
      OP_PASS: result = in_a;
      default: result = '0;
    endcase
    new_entry = {^result, |result, &result, result};
  end

  // FIFO next state: write slot on push, advance pointers, track occupancy
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      entry_d[i] = entry_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      entry_d[wr_ptr_q] = new_entry;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Match counter: clear wins, otherwise saturating increment on XNOR a==b
  always_comb begin
    match_cnt_d = match_cnt_q;
    if (clr_cnt) begin
      match_cnt_d = '0;
    end else if (push && (in_op == OP_XNOR) && (in_a == in_b) &&
                 (match_cnt_q != CNT_MAX)) begin
      match_cnt_d = match_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset discards any buffered beats
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        entry_q[i] <= '0;
      end
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      match_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        entry_q[i] <= entry_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  // Head entry drives the outputs; forced to zero while the buffer is empty
  always_comb begin
    head      = out_valid ? entry_q[rd_ptr_q] : '0;
    out_data  = head[WIDTH-1:0];
    out_all   = head[WIDTH];
    out_any   = head[WIDTH+1];
    out_par   = head[WIDTH+2];
    match_cnt = match_cnt_q;
  end

endmodule
